// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM encoding and op classification shared by alu_mdu
package alu_pkg;
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLT   = 4'h5;
  localparam logic [3:0] OP_SLTU  = 4'h6;
  localparam logic [3:0] OP_SLL   = 4'h7;
  localparam logic [3:0] OP_SRL   = 4'h8;
  localparam logic [3:0] OP_SRA   = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'ha;
  localparam logic [3:0] OP_MULHU = 4'hb;
  localparam logic [3:0] OP_DIV   = 4'hc;
  localparam logic [3:0] OP_DIVU  = 4'hd;
  localparam logic [3:0] OP_REM   = 4'he;
  localparam logic [3:0] OP_REMU  = 4'hf;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic is_iterative(input logic [3:0] op);
    return op >= OP_MUL;
  endfunction
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: shift-add multiplier and restoring divider, one bit per cycle
module mdu_iter import alu_pkg::*; #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  logic [3:0] opr;
  logic [SHW:0] cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] mc, quo, rem, dvs, q, r, ma, mb;
  logic [WIDTH:0] sum, rsh, diff;
  logic sgn, sa, sb, sq, sr;
  assign sgn = op == OP_DIV || op == OP_REM;
  assign sa = sgn && a[WIDTH-1];
  assign sb = sgn && b[WIDTH-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, prod[0] ? mc : '0};
  assign rsh = {rem, quo[WIDTH-1]};
  assign diff = rsh - {1'b0, dvs};
  assign done = cnt == (SHW+1)'(WIDTH);
  assign q = sq ? -quo : quo;
  assign r = sr ? -rem : rem;
  // A zero divisor keeps the all-ones quotient unsigned; the remainder keeps a's sign
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (start) begin
      opr <= op;
      cnt <= '0;
      prod <= {{WIDTH{1'b0}}, b};
      mc <= a;
      quo <= ma;
      rem <= '0;
      dvs <= mb;
      sq <= (sa ^ sb) && b != '0;
      sr <= sa;
    end else if (!done) begin
      cnt <= cnt + 1'b1;
      prod <= {sum, prod[WIDTH-1:1]};
      rem <= diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
    end
  // Select the finished value for the captured op
  always_comb
    result = opr == OP_MUL ? prod[WIDTH-1:0] :
             opr == OP_MULHU ? prod[2*WIDTH-1:WIDTH] :
             (opr == OP_DIV || opr == OP_DIVU) ? q : r;
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked ALU; iterative MUL/DIV unit compiled in with ALU_MDU_EN
module alu_mdu import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  state_t state;
  logic [WIDTH-1:0] res, alu_r, sra, iter_res;
  logic [SHW-1:0] sh;
  logic accept, go_busy, fin;
  assign sh = b[SHW-1:0];
  assign sra = $signed(a) >>> sh;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign result = res;
  assign zero = res == '0;
`ifdef ALU_MDU_EN
  logic iter_done;
  assign go_busy = is_iterative(op);
  assign fin = state == BUSY && iter_done;
  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk(clk), .rst(rst), .start(accept && go_busy), .op(op), .a(a), .b(b),
    .done(iter_done), .result(iter_res)
  );
`else
  assign go_busy = 1'b0;
  assign fin = 1'b0;
  assign iter_res = '0;
`endif
  // Single-cycle results; unlisted op codes yield zero
  always_comb
    alu_r = op == OP_ADD ? a + b :
            op == OP_SUB ? a - b :
            op == OP_AND ? a & b :
            op == OP_OR ? a | b :
            op == OP_XOR ? a ^ b :
            op == OP_SLT ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
            op == OP_SLTU ? {{(WIDTH-1){1'b0}}, a < b} :
            op == OP_SLL ? a << sh :
            op == OP_SRL ? a >> sh :
            op == OP_SRA ? sra : '0;
  // Request/response sequencing with registered result
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      res <= '0;
    end else if (accept) begin
      state <= go_busy ? BUSY : DONE;
      res <= alu_r;
    end else if (fin) begin
      state <= DONE;
      res <= iter_res;
    end else if (state == DONE && out_ready) state <= IDLE;
endmodule
